conv_sequencer: RTL and testbench
=================================

# conv_sequencer

Control FSM for the convolution engine. It latches the matrix size, steers the input pixel stream into the line/frame buffer, then scans every output position of a same-size 3x3 convolution. For each tap it issues a buffer read address, or a zero-pad flag when the tap falls outside the matrix. It sits between the top-level I/O and the buffer/padding/MAC datapath; it computes no arithmetic itself.

## Interface
- `DATA_W`, default 8: pixel width (pass-through only, used for `pix_in`).
- `MAX_N`, default 16: largest supported matrix side.
- `ADDR_W`, default `$clog2(MAX_N*MAX_N)`: buffer address width.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: one clock; reset is synchronous and active-high.
- `start`  in  1: one-cycle request to begin a job; sampled only in IDLE.
- `size`  in  5: matrix side N; latched on accepted `start`.
- `pix_valid`  in  1: input pixel valid.
- `pix_ready`  out  1: sequencer accepts a pixel; high only in LOAD.
- `buf_we`  out  1: buffer write strobe (= `pix_valid & pix_ready`).
- `buf_waddr`  out  ADDR_W: write address, row-major `r*N+c`.
- `buf_raddr`  out  ADDR_W: read address for the current tap.
- `tap_valid`  out  1: tap info valid; aligned with buffer read data (1-cycle RAM).
- `tap_pad`  out  1: with `tap_valid`, the datapath must use 0 instead of buffer data.
- `tap_idx`  out  4: kernel tap index 0..8, `kr*3+kc`.
- `tap_last`  out  1: with `tap_valid`, marks tap 8 (window complete).
- `out_row`, `out_col`  out  5 each: output coordinate of the current window.
- `busy`  out  1: high in any state except IDLE.
- `done`  out  1: one-cycle pulse at job end.
- `err`  out  1: one-cycle pulse when `start` carries an illegal size.

## Operation
- States: IDLE, LOAD, SCAN, DRAIN, DONE.
- IDLE:
  - On `start` with 3 <= `size` <= MAX_N: latch N, clear counters, go to LOAD.
  - On `start` with an illegal size: pulse `err` and stay in IDLE.
  - `start` while not IDLE is ignored.
- LOAD:
  - `pix_ready`=1.
  - Each accepted pixel writes `buf_waddr` and advances (c, r) row-major.
  - After N*N accepts, go to SCAN. Stalls indefinitely if `pix_valid`=0.
- SCAN:
  - One tap per cycle, no stalls. Loop order: out_row, out_col, kr, kc (kc innermost).
  - Tap coordinate is (row+kr-1, col+kc-1).
  - If either component is <0 or >=N, the tap is padded: `tap_pad`=1 and `buf_raddr` holds its previous value.
  - Otherwise `buf_raddr` = `(row+kr-1)*N + (col+kc-1)`.
  - After issuing the tap for (N-1, N-1, kr=2, kc=2), go to DRAIN.
- DRAIN: one cycle to emit the final registered tap, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Arithmetic:
  - Coordinates are computed in 6-bit signed to detect -1.
  - Address multiply is N*row with ADDR_W bits; no wrap is possible for legal N.

## Timing
- Reset values: state IDLE; all counters 0; `pix_ready`, `buf_we`, `tap_valid`, `tap_pad`, `tap_last`, `busy`, `done`, `err` all 0; `buf_waddr`, `buf_raddr`, `tap_idx`, `out_row`, `out_col` all 0.
- `rst` asserted in any state: next edge returns to IDLE with reset values. No `done` is emitted for the aborted job.
- `busy` rises the cycle after the accepted `start`.
- `pix_ready` rises the same cycle as entry to LOAD.
- `buf_we` and `buf_waddr` are combinational from the current count and the handshake.
- Tap metadata (`tap_valid`, `tap_pad`, `tap_idx`, `tap_last`, `out_row`, `out_col`) is registered one cycle after its `buf_raddr`, so it matches RAM output.
- SCAN duration is 9*N*N cycles; the first `tap_valid` appears 1 cycle after SCAN entry.
- `done` is asserted 1 cycle after the last `tap_valid`.
- Job latency from `start` to `done`: 1 + N*N (LOAD, no stalls) + 9*N*N + 1 + 1 cycles.
- `start` is ignored in the same cycle as `done`; a new job may start the cycle after.

## Structure
- Shared package `conv_pkg` holds:
  - the state enum;
  - `KERNEL_SIZE`=3, `TAPS`=9, `MAX_N`;
  - the `tap_t` struct (valid, pad, idx, last, row, col).
- One sub-module, `conv_tap_gen`: nested row/col/kr/kc counters with bounds checks, producing the address and pad flag.
- The FSM, load counter and output register stage stay in `conv_sequencer`.

## Test plan
- Reset mid-SCAN (N=4, after 20 taps): next cycle `busy`=0, `tap_valid`=0, no `done`; a fresh `start` (N=4) then runs normally.
- Illegal sizes: `start` with `size`=2, then `size`=17 -> one `err` pulse each, `busy` stays 0, `pix_ready` stays 0.
- N=3, 9 pixels with no stalls:
  - `buf_waddr` runs 0..8;
  - SCAN gives 81 `tap_valid`;
  - window (0,0) pads taps 0,1,2,3,6, and tap 4 reads addr 0;
  - `done` exactly 93 cycles after `start`.
- N=4 with `pix_valid` toggling every other cycle: exactly 16 `buf_we` at addresses 0..15 in order; SCAN does not start until the 16th accept.
- N=16 (MAX_N):
  - window (15,15) tap 8 padded, tap 4 reads addr 255;
  - 2304 taps total;
  - `tap_last` count = 256.
- `start` asserted during LOAD and during DONE: ignored; no restart, and the counters do not change.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution sequencer and its tap generator.
package conv_pkg;

    localparam int unsigned KERNEL_SIZE = 3;
    localparam int unsigned TAPS        = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned MAX_N       = 16;
    localparam int unsigned COORD_W     = 5;
    localparam int unsigned IDX_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic               valid;
        logic               pad;
        logic [IDX_W-1:0]   idx;
        logic               last;
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
    } tap_t;

endpackage

// File: rtl/conv_tap_gen.sv
// Nested row/col/kr/kc scan counters; decodes the current tap into a buffer
// address and a zero-pad flag for taps that fall outside the N x N matrix.
module conv_tap_gen
    import conv_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_step,
    input  logic [COORD_W-1:0] i_n,
    output logic [ADDR_W-1:0]  o_addr_c,
    output logic               o_pad_c,
    output logic [IDX_W-1:0]   o_idx_c,
    output logic               o_last_c,
    output logic               o_final_c,
    output logic [COORD_W-1:0] o_row,
    output logic [COORD_W-1:0] o_col
);

    localparam logic [1:0]                K_LAST = 2'(KERNEL_SIZE - 1);
    localparam logic signed [COORD_W:0]   S_ONE  = (COORD_W + 1)'(1);

    logic [COORD_W-1:0]        r_row;
    logic [COORD_W-1:0]        r_col;
    logic [1:0]                r_kr;
    logic [1:0]                r_kc;
    logic signed [COORD_W:0]   w_tr;
    logic signed [COORD_W:0]   w_tc;
    logic signed [COORD_W:0]   w_n;
    logic [COORD_W-1:0]        w_n_m1;

    // Tap coordinate in one extra signed bit so that -1 is visible
    assign w_n    = $signed({1'b0, i_n});
    assign w_n_m1 = i_n - COORD_W'(1);
    assign w_tr   = $signed({1'b0, r_row}) + $signed({{(COORD_W-1){1'b0}}, r_kr}) - S_ONE;
    assign w_tc   = $signed({1'b0, r_col}) + $signed({{(COORD_W-1){1'b0}}, r_kc}) - S_ONE;

    assign o_pad_c   = w_tr[COORD_W] || w_tc[COORD_W] || (w_tr >= w_n) || (w_tc >= w_n);
    assign o_addr_c  = ADDR_W'(w_tr[COORD_W-1:0]) * ADDR_W'(i_n) + ADDR_W'(w_tc[COORD_W-1:0]);
    assign o_idx_c   = IDX_W'(r_kr) * IDX_W'(KERNEL_SIZE) + IDX_W'(r_kc);
    assign o_last_c  = (o_idx_c == IDX_W'(TAPS - 1));
    assign o_final_c = o_last_c && (r_row == w_n_m1) && (r_col == w_n_m1);
    assign o_row     = r_row;
    assign o_col     = r_col;

    // kc innermost, then kr, col, row; wraps to the origin after the final tap
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_row <= '0;
            r_col <= '0;
            r_kr  <= '0;
            r_kc  <= '0;
        end else if (i_step) begin
            if (r_kc != K_LAST) begin
                r_kc <= r_kc + 2'd1;
            end else begin
                r_kc <= '0;
                if (r_kr != K_LAST) begin
                    r_kr <= r_kr + 2'd1;
                end else begin
                    r_kr <= '0;
                    if (r_col != w_n_m1) begin
                        r_col <= r_col + COORD_W'(1);
                    end else begin
                        r_col <= '0;
                        r_row <= (r_row != w_n_m1) ? r_row + COORD_W'(1) : '0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// Control FSM for the convolution engine: loads an N x N frame into the buffer,
// then streams buffer read addresses / pad flags for every 3x3 tap of every output.
module conv_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned MAX_N  = conv_pkg::MAX_N,
    parameter int unsigned ADDR_W = $clog2(MAX_N * MAX_N)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [conv_pkg::COORD_W-1:0] size,
    input  logic                         pix_valid,
    input  logic [DATA_W-1:0]            pix_in,
    output logic                         pix_ready,
    output logic                         buf_we,
    output logic [ADDR_W-1:0]            buf_waddr,
    output logic [DATA_W-1:0]            buf_wdata,
    output logic [ADDR_W-1:0]            buf_raddr,
    output logic                         tap_valid,
    output logic                         tap_pad,
    output logic [conv_pkg::IDX_W-1:0]   tap_idx,
    output logic                         tap_last,
    output logic [conv_pkg::COORD_W-1:0] out_row,
    output logic [conv_pkg::COORD_W-1:0] out_col,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    import conv_pkg::*;

    localparam int unsigned SQ_W = 2 * COORD_W;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [COORD_W-1:0]  r_n;
    logic [ADDR_W-1:0]   r_load_cnt;
    logic                r_all_issued;
    logic [ADDR_W-1:0]   r_raddr;
    logic                r_err;
    tap_t                r_stage;
    tap_t                r_tap;
    tap_t                w_stage_d;

    logic [SQ_W-1:0]     w_sq;
    logic [ADDR_W-1:0]   w_cnt_last;
    logic                w_size_ok;
    logic                w_accept;
    logic                w_load_last;
    logic                w_issue;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_pad;
    logic [IDX_W-1:0]    w_idx;
    logic                w_last;
    logic                w_final;
    logic [COORD_W-1:0]  w_row;
    logic [COORD_W-1:0]  w_col;

    assign w_sq        = SQ_W'(r_n) * SQ_W'(r_n);
    assign w_cnt_last  = ADDR_W'(w_sq - SQ_W'(1));
    assign w_size_ok   = (size >= COORD_W'(KERNEL_SIZE)) && (32'(size) <= MAX_N);
    assign w_accept    = (r_state == ST_IDLE) && start && w_size_ok;
    assign w_load_last = buf_we && (r_load_cnt == w_cnt_last);
    // Tap 0 is issued on the final pixel accept so its address is live on SCAN entry
    assign w_issue     = w_load_last || ((r_state == ST_SCAN) && !r_all_issued);

    assign buf_we    = pix_valid && pix_ready;
    assign buf_waddr = r_load_cnt;
    assign buf_wdata = pix_in;
    assign buf_raddr = r_raddr;
    assign tap_valid = r_tap.valid;
    assign tap_pad   = r_tap.pad;
    assign tap_idx   = r_tap.idx;
    assign tap_last  = r_tap.last;
    assign out_row   = r_tap.row;
    assign out_col   = r_tap.col;
    assign err       = r_err;

    conv_tap_gen #(
        .ADDR_W (ADDR_W)
    ) u_tap_gen (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_accept),
        .i_step    (w_issue),
        .i_n       (r_n),
        .o_addr_c  (w_addr),
        .o_pad_c   (w_pad),
        .o_idx_c   (w_idx),
        .o_last_c  (w_last),
        .o_final_c (w_final),
        .o_row     (w_row),
        .o_col     (w_col)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)     w_state_nxt = ST_LOAD;
            ST_LOAD:  if (w_load_last)  w_state_nxt = ST_SCAN;
            ST_SCAN:  if (r_all_issued) w_state_nxt = ST_DRAIN;
            ST_DRAIN: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pix_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_IDLE:  busy = 1'b0;
            ST_LOAD:  begin pix_ready = 1'b1; busy = 1'b1; end
            ST_DONE:  begin done = 1'b1; busy = 1'b1; end
            default:  busy = 1'b1;
        endcase
    end

    always_comb begin
        w_stage_d = '0;
        if (w_issue) begin
            w_stage_d.valid = 1'b1;
            w_stage_d.pad   = w_pad;
            w_stage_d.idx   = w_idx;
            w_stage_d.last  = w_last;
            w_stage_d.row   = w_row;
            w_stage_d.col   = w_col;
        end
    end

    // Load counter, read address and the two-deep tap metadata pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n          <= '0;
            r_load_cnt   <= '0;
            r_all_issued <= 1'b0;
            r_raddr      <= '0;
            r_err        <= 1'b0;
            r_stage      <= '0;
            r_tap        <= '0;
        end else begin
            r_err <= (r_state == ST_IDLE) && start && !w_size_ok;
            if (w_accept) begin
                r_n          <= size;
                r_load_cnt   <= '0;
                r_all_issued <= 1'b0;
            end else begin
                if (buf_we) begin
                    r_load_cnt <= r_load_cnt + ADDR_W'(1);
                end
                if (w_issue && w_final) begin
                    r_all_issued <= 1'b1;
                end
            end
            if (w_issue && !w_pad) begin
                r_raddr <= w_addr;
            end
            r_stage <= w_stage_d;
            r_tap   <= r_stage;
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: job table, reference tap stream built
// from the 3x3 same-padding rules, an attached 1-cycle RAM, and corner sequences.
module tb_conv_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] size;
    logic       pix_valid;
    logic [7:0] pix_in;
    logic       pix_ready;
    logic       buf_we;
    logic [7:0] buf_waddr;
    logic [7:0] buf_wdata;
    logic [7:0] buf_raddr;
    logic       tap_valid;
    logic       tap_pad;
    logic [3:0] tap_idx;
    logic       tap_last;
    logic [4:0] out_row;
    logic [4:0] out_col;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    int m_hold = 0;

    logic [7:0] ram [256];
    logic [7:0] ram_q;

    typedef struct {
        bit pad;
        int idx;
        bit last;
        int row;
        int col;
        int addr;
    } tap_rec_t;

    typedef struct {
        int size;
        int mode;
        bit poke;
        bit legal;
    } job_vec_t;

    conv_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .size      (size),
        .pix_valid (pix_valid),
        .pix_in    (pix_in),
        .pix_ready (pix_ready),
        .buf_we    (buf_we),
        .buf_waddr (buf_waddr),
        .buf_wdata (buf_wdata),
        .buf_raddr (buf_raddr),
        .tap_valid (tap_valid),
        .tap_pad   (tap_pad),
        .tap_idx   (tap_idx),
        .tap_last  (tap_last),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Line/frame buffer stand-in with one cycle of read latency
    always @(posedge clk) begin
        if (buf_we) ram[buf_waddr] <= buf_wdata;
        ram_q <= ram[buf_raddr];
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // mode 0: pix_valid always high, 1: toggling, 2: random stalls.
    // poke: also drive start once during LOAD and once during the DONE cycle.
    task automatic run_job(input int n, input int mode, input bit poke);
        tap_rec_t   q[$];
        tap_rec_t   e;
        logic [7:0] pixels [256];
        logic [8:0] pad00;
        logic [8:0] padcc;
        logic [7:0] prev_raddr;
        int cyc, wcount, last_acc, taps, lasts, done_cyc;
        bit fin;

        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++) begin
                        int tr;
                        int tc;
                        tr = r + kr - 1;
                        tc = c + kc - 1;
                        e.pad = (tr < 0) || (tr >= n) || (tc < 0) || (tc >= n);
                        if (!e.pad) m_hold = tr * n + tc;
                        e.idx  = kr * 3 + kc;
                        e.last = (kr == 2) && (kc == 2);
                        e.row  = r;
                        e.col  = c;
                        e.addr = m_hold;
                        q.push_back(e);
                    end

        @(negedge clk);
        start = 1'b1; size = 5'(n); pix_valid = 1'b0;
        #1;
        prev_raddr = buf_raddr;
        cyc = 0; wcount = 0; last_acc = -1; taps = 0; lasts = 0; done_cyc = -1; fin = 0;
        pad00 = '0; padcc = '0;

        while (!fin && cyc < 20 * n * n + 50) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (poke && cyc == 3) begin start = 1'b1; size = 5'd5; end
            if (poke && last_acc >= 0 && cyc == last_acc + 9 * n * n + 2) begin
                start = 1'b1; size = 5'd3;
            end
            case (mode)
                0:       pix_valid = 1'b1;
                1:       pix_valid = cyc[0];
                default: pix_valid = ($urandom_range(0, 3) != 0);
            endcase
            pix_in = 8'($urandom);
            #1;
            if (cyc == 1) begin
                check("busy_after_start", busy, 1);
                check("pix_ready_on_load", pix_ready, 1);
                check("no_err_legal", err, 0);
            end
            if (last_acc >= 0 && cyc == last_acc + 1) check("pix_ready_after_load", pix_ready, 0);
            if (buf_we) begin
                check("buf_waddr", buf_waddr, wcount);
                if (wcount < 256) pixels[wcount] = pix_in;
                wcount++;
                if (wcount == n * n) last_acc = cyc;
            end
            if (tap_valid) begin
                if (taps == 0) check("first_tap_cycle", cyc, last_acc + 2);
                taps++;
                if (tap_last) lasts++;
                if (q.size() == 0) begin
                    check("extra_tap", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("tap_meta", {tap_pad, tap_idx, tap_last, out_row, out_col},
                          {e.pad, 4'(e.idx), e.last, 5'(e.row), 5'(e.col)});
                    check("tap_raddr", prev_raddr, e.addr);
                    if (!e.pad) check("tap_pixel", ram_q, pixels[e.addr]);
                    if (e.row == 0 && e.col == 0) begin
                        pad00[e.idx] = tap_pad;
                        if (e.idx == 4) check("win00_tap4_addr", prev_raddr, 0);
                    end
                    if (e.row == n - 1 && e.col == n - 1) begin
                        padcc[e.idx] = tap_pad;
                        if (e.idx == 4) check("wincorner_tap4_addr", prev_raddr, n * n - 1);
                    end
                end
            end
            if (done) begin
                done_cyc = cyc;
                fin = 1;
            end
            prev_raddr = buf_raddr;
        end

        if (!fin) check("job_timeout", 1, 0);
        check("accept_count", wcount, n * n);
        check("tap_count", taps, 9 * n * n);
        check("tap_last_count", lasts, n * n);
        check("done_after_last_accept", done_cyc, last_acc + 9 * n * n + 2);
        // Start cycle through done cycle inclusive
        if (mode == 0) check("job_cycles", done_cyc + 1, 10 * n * n + 3);
        check("win00_pad_mask", pad00, 9'h04F);
        check("wincorner_pad_mask", padcc, 9'h1E4);

        @(negedge clk);
        start = 1'b0; pix_valid = 1'b0;
        #1;
        check("idle_after_done_busy", busy, 0);
        check("done_one_pulse", done, 0);
        check("no_tap_after_done", tap_valid, 0);
    endtask

    task automatic illegal_start(input int sz);
        @(negedge clk);
        start = 1'b1; size = 5'(sz); pix_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("err_pulse", err, 1);
        check("illegal_busy", busy, 0);
        check("illegal_pix_ready", pix_ready, 0);
        @(negedge clk);
        pix_valid = 1'b0;
        #1;
        check("err_one_cycle", err, 0);
        check("illegal_busy_later", busy, 0);
    endtask

    task automatic reset_mid_scan();
        int cnt;
        int guard;
        int dones;
        @(negedge clk);
        start = 1'b1; size = 5'd4; pix_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; pix_valid = 1'b1;
        cnt = 0; guard = 0;
        while (cnt < 20 && guard < 200) begin
            #1;
            if (tap_valid) cnt++;
            @(negedge clk);
            guard++;
        end
        check("taps_before_reset", cnt, 20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; pix_valid = 1'b0;
        m_hold = 0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_tap_valid", tap_valid, 0);
        check("rst_done", done, 0);
        check("rst_raddr", buf_raddr, 0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (done || tap_valid) dones++;
        end
        check("no_done_after_abort", dones, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        job_vec_t vec [10];
        vec[0] = '{size: 2,  mode: 0, poke: 0, legal: 0};
        vec[1] = '{size: 17, mode: 0, poke: 0, legal: 0};
        vec[2] = '{size: 3,  mode: 0, poke: 0, legal: 1};
        vec[3] = '{size: 4,  mode: 1, poke: 0, legal: 1};
        vec[4] = '{size: 0,  mode: 0, poke: 0, legal: 0};
        vec[5] = '{size: 16, mode: 0, poke: 1, legal: 1};
        vec[6] = '{size: 31, mode: 0, poke: 0, legal: 0};
        vec[7] = '{size: 5,  mode: 2, poke: 1, legal: 1};
        vec[8] = '{size: 9,  mode: 2, poke: 0, legal: 1};
        vec[9] = '{size: 1,  mode: 0, poke: 0, legal: 0};

        rst = 1'b1; start = 1'b0; size = '0; pix_valid = 1'b0; pix_in = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_pix_ready", pix_ready, 0);
        check("reset_tap_flags", {tap_valid, tap_pad, tap_last, done, err, buf_we}, 0);
        check("reset_addrs", {buf_waddr, buf_raddr}, 0);
        check("reset_tap_pos", {tap_idx, out_row, out_col}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (vec[i].legal) run_job(vec[i].size, vec[i].mode, vec[i].poke);
            else              illegal_start(vec[i].size);
        end

        reset_mid_scan();
        run_job(4, 0, 1'b0);

        for (int k = 0; k < 2; k++) run_job(int'($urandom_range(3, 16)), 2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
